// File: rtl/div_ctrl_if.sv
// Handshake and datapath-strobe bundle between the divider controller, its requester and the datapath.
interface div_ctrl_if;
    logic start;
    logic abort;
    logic co;
    logic ready;
    logic busy;
    logic done;
    logic err;
    logic init_dend;
    logic init_q;
    logic ld_disor;
    logic ld_cnt;
    logic sh_dend;
    logic sh_q;
    logic sIn_q;
    logic ld_dend;
    logic ld_q;
    logic cnt_en;
    logic clr_dend;
    logic clr_q;
    logic clr_disor;

    modport slave (
        input  start, abort, co,
        output ready, busy, done, err,
        output init_dend, init_q, ld_disor, ld_cnt,
        output sh_dend, sh_q, sIn_q,
        output ld_dend, ld_q, cnt_en,
        output clr_dend, clr_q, clr_disor
    );

    modport master (
        output start, abort, co,
        input  ready, busy, done, err,
        input  init_dend, init_q, ld_disor, ld_cnt,
        input  sh_dend, sh_q, sIn_q,
        input  ld_dend, ld_q, cnt_en,
        input  clr_dend, clr_q, clr_disor
    );
endinterface

// File: rtl/div_ctrl.sv
// Moore controller for the 13-by-6 restoring divider: load, six shift/restore rounds, done.
// Outputs are registered from the next-state decode, so they always equal the decode of the state register.
module div_ctrl #(
    parameter int unsigned MAX_ITER = 8,
    parameter int unsigned WD_W     = 4
) (
    input  logic      clk,
    input  logic      rst,
    div_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        SHIFT = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4,
        CLEAR = 3'd5
    } state_t;

    typedef struct packed {
        logic ready;
        logic busy;
        logic done;
        logic err;
        logic init_dend;
        logic init_q;
        logic ld_disor;
        logic ld_cnt;
        logic sh_dend;
        logic sh_q;
        logic ld_dend;
        logic ld_q;
        logic cnt_en;
        logic clr_dend;
        logic clr_q;
        logic clr_disor;
    } ctrl_t;

    state_t          state, state_nxt;
    logic [WD_W-1:0] wd, wd_nxt, wd_inc;
    logic            wd_trip;
    ctrl_t           ctrl, ctrl_nxt;

    assign wd_inc = wd + WD_W'(1);

    // Next-state and output decode of the next state
    always_comb begin
        state_nxt = IDLE;
        wd_nxt    = wd;
        wd_trip   = 1'b0;
        ctrl_nxt  = '0;

        case (state)
            IDLE:  state_nxt = bus.start ? INIT : IDLE;
            INIT: begin
                state_nxt = SHIFT;
                wd_nxt    = '0;
            end
            SHIFT: state_nxt = bus.abort ? CLEAR : LOAD;
            LOAD: begin
                wd_nxt = wd_inc;
                // abort beats co; the watchdog only fires when neither is present
                if (bus.abort) begin
                    state_nxt = CLEAR;
                end else if (bus.co) begin
                    state_nxt = DONE;
                end else if (wd_inc == WD_W'(MAX_ITER)) begin
                    state_nxt = CLEAR;
                    wd_trip   = 1'b1;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            DONE:    state_nxt = IDLE;
            CLEAR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            IDLE: ctrl_nxt.ready = 1'b1;
            INIT: begin
                ctrl_nxt.busy      = 1'b1;
                ctrl_nxt.init_dend = 1'b1;
                ctrl_nxt.init_q    = 1'b1;
                ctrl_nxt.ld_disor  = 1'b1;
                ctrl_nxt.ld_cnt    = 1'b1;
            end
            SHIFT: begin
                ctrl_nxt.busy    = 1'b1;
                ctrl_nxt.sh_dend = 1'b1;
                ctrl_nxt.sh_q    = 1'b1;
            end
            LOAD: begin
                ctrl_nxt.busy    = 1'b1;
                ctrl_nxt.ld_dend = 1'b1;
                ctrl_nxt.ld_q    = 1'b1;
                ctrl_nxt.cnt_en  = 1'b1;
            end
            DONE: ctrl_nxt.done = 1'b1;
            CLEAR: begin
                ctrl_nxt.clr_dend  = 1'b1;
                ctrl_nxt.clr_q     = 1'b1;
                ctrl_nxt.clr_disor = 1'b1;
                ctrl_nxt.err       = wd_trip;
            end
            default: ctrl_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wd    <= '0;
            ctrl  <= '0;
            ctrl.ready <= 1'b1;
        end else begin
            state <= state_nxt;
            wd    <= wd_nxt;
            ctrl  <= ctrl_nxt;
        end
    end

    assign bus.ready     = ctrl.ready;
    assign bus.busy      = ctrl.busy;
    assign bus.done      = ctrl.done;
    assign bus.err       = ctrl.err;
    assign bus.init_dend = ctrl.init_dend;
    assign bus.init_q    = ctrl.init_q;
    assign bus.ld_disor  = ctrl.ld_disor;
    assign bus.ld_cnt    = ctrl.ld_cnt;
    assign bus.sh_dend   = ctrl.sh_dend;
    assign bus.sh_q      = ctrl.sh_q;
    assign bus.sIn_q     = 1'b0;
    assign bus.ld_dend   = ctrl.ld_dend;
    assign bus.ld_q      = ctrl.ld_q;
    assign bus.cnt_en    = ctrl.cnt_en;
    assign bus.clr_dend  = ctrl.clr_dend;
    assign bus.clr_q     = ctrl.clr_q;
    assign bus.clr_disor = ctrl.clr_disor;
endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl driving a behavioural restoring-divider datapath.
module tb_div_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    div_ctrl_if bus ();

    div_ctrl #(.MAX_ITER(8), .WD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: partial remainder r, low dividend bits lo, quotient q, divisor d, iteration counter cnt
    logic [12:0] dividend;
    logic [5:0]  divisor;
    logic [7:0]  r;
    logic [5:0]  lo, q, d;
    logic [2:0]  cnt;
    int          co_mode = 0;

    assign bus.co = (co_mode == 1) ? 1'b0 : (cnt == 3'd7);

    always @(posedge clk) begin
        if (bus.init_dend) begin
            r  <= {2'b00, dividend[12:6]};
            lo <= dividend[5:0];
        end
        if (bus.init_q)   q <= '0;
        if (bus.ld_disor) d <= divisor;
        if (bus.ld_cnt)   cnt <= 3'd2;
        if (bus.cnt_en)   cnt <= cnt + 3'd1;
        if (bus.sh_dend)  {r, lo} <= {r[6:0], lo, 1'b0};
        if (bus.sh_q)     q <= {q[4:0], bus.sIn_q};
        if (bus.ld_dend && r >= {2'b00, d}) r <= r - {2'b00, d};
        if (bus.ld_q && r >= {2'b00, d})    q[0] <= 1'b1;
        if (bus.clr_dend)  begin r <= '0; lo <= '0; end
        if (bus.clr_q)     q <= '0;
        if (bus.clr_disor) d <= '0;
    end

    typedef struct {
        bit         is_done;
        int         cyc;
        bit         err;
        bit         chk_val;
        logic [5:0] q;
        logic [6:0] rem;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: strobe exclusivity each cycle, scoreboard pop on done/clear events
    bit pend_ready = 0;
    bit prev_sh = 0;
    int n_sh = 0, n_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            int grp;
            grp = int'(|{bus.init_dend, bus.init_q, bus.ld_disor, bus.ld_cnt})
                + int'(|{bus.sh_dend, bus.sh_q})
                + int'(|{bus.ld_dend, bus.ld_q, bus.cnt_en})
                + int'(|{bus.clr_dend, bus.clr_q, bus.clr_disor});
            chk("strobe_groups_le1", int'(grp <= 1), 1);
            chk("sIn_q_zero", int'(bus.sIn_q), 0);

            if (bus.init_dend) begin n_sh = 0; n_cnt = 0; prev_sh = 0; end
            if (bus.sh_dend) begin
                chk("shift_after_nonshift", int'(prev_sh), 0);
                n_sh++;
            end
            if (bus.ld_dend) chk("load_after_shift", int'(prev_sh), 1);
            if (bus.cnt_en) n_cnt++;
            prev_sh = bus.sh_dend;

            if (pend_ready) begin
                chk("ready_after_event", int'(bus.ready), 1);
                chk("err_one_cycle", int'(bus.err), 0);
                pend_ready = 0;
            end

            if (bus.done || bus.clr_dend || bus.clr_q || bus.clr_disor) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("event_kind_done", int'(bus.done), int'(e.is_done));
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_err", int'(bus.err), int'(e.err));
                    if (e.is_done) begin
                        chk("shift_count", n_sh, 6);
                        chk("cnt_en_count", n_cnt, 6);
                        if (e.chk_val) begin
                            chk("quotient", int'(q), int'(e.q));
                            chk("remainder", int'(r[6:0]), int'(e.rem));
                        end
                    end else begin
                        chk("clr_strobes", int'({bus.clr_dend, bus.clr_q, bus.clr_disor}), 7);
                    end
                    pend_ready = 1;
                end
            end
        end
    end

    task automatic push(input bit is_done, input int c, input bit err, input bit cv,
                        input logic [5:0] eq, input logic [6:0] er);
        exp_t e;
        e.is_done = is_done; e.cyc = c; e.err = err; e.chk_val = cv; e.q = eq; e.rem = er;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns the cycle number of the edge that samples start
    task automatic start_op(input logic [12:0] dd, input logic [5:0] dv, output int ct);
        dividend  = dd;
        divisor   = dv;
        bus.start = 1'b1;
        ct = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_cyc_timeout", int'(cyc >= n), 1);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int ct, c0, outs;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        dividend = '0;
        divisor  = 6'd1;
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done_err", int'({bus.done, bus.err}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", int'(bus.ready), 1);

        // abort and co in IDLE have no effect
        bus.abort = 1'b1;
        co_mode = 0;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("idle_abort_ignored", int'(bus.ready), 1);

        // 100 / 7 = 14 r 2
        start_op(13'd100, 6'd7, ct);
        chk("init_busy", int'(bus.busy & bus.init_dend & bus.ld_cnt), 1);
        push(1, ct + 13, 0, 1, 6'd14, 7'd2);
        drain();

        // 4095 / 63 overflows the quotient; only timing and pulse counts matter
        start_op(13'd4095, 6'd63, ct);
        push(1, ct + 13, 0, 0, 6'd0, 7'd0);
        drain();

        // abort during the 3rd SHIFT
        start_op(13'd200, 6'd9, ct);
        push(0, ct + 6, 0, 0, 6'd0, 7'd0);
        wait_cyc(ct + 5);
        chk("third_shift", int'(bus.sh_dend), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        drain();

        // abort together with co in the 6th LOAD: clear wins, no done
        start_op(13'd100, 6'd7, ct);
        push(0, ct + 13, 0, 0, 6'd0, 7'd0);
        wait_cyc(ct + 12);
        chk("load6_co", int'(bus.co & bus.ld_dend), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        drain();

        // stuck co: watchdog trips after the 8th LOAD
        co_mode = 1;
        start_op(13'd100, 6'd7, ct);
        push(0, ct + 17, 1, 0, 6'd0, 7'd0);
        drain();
        co_mode = 0;

        // async reset in the middle of LOAD, between clock edges
        start_op(13'd100, 6'd7, ct);
        wait_cyc(ct + 2);
        chk("mid_load", int'(bus.ld_dend), 1);
        #2 rst = 1'b1;
        #1;
        outs = int'({bus.busy, bus.done, bus.err, bus.init_dend, bus.init_q, bus.ld_disor,
                     bus.ld_cnt, bus.sh_dend, bus.sh_q, bus.ld_dend, bus.ld_q, bus.cnt_en,
                     bus.clr_dend, bus.clr_q, bus.clr_disor});
        chk("async_rst_outputs_low", outs, 0);
        chk("async_rst_ready", int'(bus.ready), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_op(13'd100, 6'd7, ct);
        push(1, ct + 13, 0, 1, 6'd14, 7'd2);
        drain();

        // start held for 40 cycles: accepted at T, T+15, T+30
        dividend  = 13'd100;
        divisor   = 6'd7;
        bus.start = 1'b1;
        c0 = cyc + 1;
        push(1, c0 + 13, 0, 1, 6'd14, 7'd2);
        push(1, c0 + 28, 0, 1, 6'd14, 7'd2);
        push(1, c0 + 43, 0, 1, 6'd14, 7'd2);
        repeat (40) @(negedge clk);
        bus.start = 1'b0;
        drain();

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
